// File: rtl/stage_4.sv
// stage_4: RV32I memory-access stage, loads/stores over a single-outstanding req/ack bus.
//   in : clk, rst_n, i_valid, i_alu_out, i_rs_2, i_rd_num, i_opcode, i_func_3, i_op_type,
//        mem_ack, mem_rdata
//   out: o_stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
//        wb_valid, wb_we, wb_rd_num, wb_data, o_align_err, o_bus_err
module stage_4 #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func_3,
  input  logic        i_op_type,
  output logic        o_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd_num,
  output logic [31:0] wb_data,
  output logic        o_align_err,
  output logic        o_bus_err
);
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  typedef enum logic {IDLE, BUS} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        wb_valid_q, wb_we_q, align_q, bus_err_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        accept, is_st, illegal, go_bus, done, timeout, alu_we;
  logic [1:0]  sz;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, sh, ld_d;
  assign accept  = i_valid && state_q == IDLE;
  assign is_st   = i_opcode == STORE;
  assign sz      = i_func_3[1:0];
  assign illegal = sz == 2'b11 || (is_st && i_func_3[2]) || (sz == 2'b01 && i_alu_out[0])
                   || (sz == 2'b10 && i_alu_out[1:0] != 2'b00);
  assign go_bus  = accept && i_op_type && !illegal;
  assign done    = state_q == BUS && mem_ack;
  // Abort on the edge that would make the request MAX_WAIT cycles long.
  assign timeout = state_q == BUS && !mem_ack && cnt_q == 8'(MAX_WAIT - 1);
  assign alu_we  = i_rd_num != 5'd0 && i_opcode != STORE && i_opcode != BRANCH;
  always_comb begin
    state_d = go_bus ? BUS : (done || timeout) ? IDLE : state_q;
  end
  always_comb begin
    mem_req = state_q == BUS;
    o_stall = state_q == BUS;
  end
  always_comb begin
    be_d    = sz == 2'b00 ? 4'b0001 << i_alu_out[1:0] : sz == 2'b01 ? (i_alu_out[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_d = sz == 2'b00 ? {4{i_rs_2[7:0]}} : sz == 2'b01 ? {2{i_rs_2[15:0]}} : i_rs_2;
    sh      = mem_rdata >> {lo_q, 3'b000};
    ld_d    = f3_q[1] ? mem_rdata
            : f3_q[0] ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]}
            : {{24{~f3_q[2] & sh[7]}}, sh[7:0]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_q       <= '0;
      f3_q       <= '0;
      lo_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      align_q    <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= go_bus ? 8'd0 : state_q == BUS ? cnt_q + 8'd1 : cnt_q;
      wb_valid_q <= (accept && !i_op_type) || done;
      wb_we_q    <= (accept && !i_op_type) ? alu_we : done ? (!we_q && rd_q != 5'd0) : 1'b0;
      align_q    <= accept && i_op_type && illegal;
      bus_err_q  <= timeout;
      if (accept && !i_op_type) begin
        wb_rd_q   <= i_rd_num;
        wb_data_q <= i_alu_out;
      end
      if (done) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= we_q ? 32'd0 : ld_d;
      end
      if (go_bus) begin
        addr_q  <= {i_alu_out[31:2], 2'b00};
        we_q    <= is_st;
        be_q    <= be_d;
        wdata_q <= is_st ? wdata_d : 32'd0;
        rd_q    <= i_rd_num;
        f3_q    <= i_func_3;
        lo_q    <= i_alu_out[1:0];
      end
    end
  end
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign wb_valid    = wb_valid_q;
  assign wb_we       = wb_we_q;
  assign wb_rd_num   = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign o_align_err = align_q;
  assign o_bus_err   = bus_err_q;
endmodule

// File: tb/tb_stage_4.sv
// tb_stage_4: table-driven, scoreboarded bench for stage_4 (MAX_WAIT=4).
module tb_stage_4;
  localparam logic [6:0] OPI = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_valid = 0, i_op_type = 0, mem_ack = 0;
  logic [31:0] i_alu_out = 0, i_rs_2 = 0, mem_rdata = 0;
  logic [4:0] i_rd_num = 0;
  logic [6:0] i_opcode = 0;
  logic [2:0] i_func_3 = 0;
  logic o_stall, mem_req, mem_we, wb_valid, wb_we, o_align_err, o_bus_err;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0] mem_be;
  logic [4:0] wb_rd_num;
  always #5 clk = ~clk;
  stage_4 #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_alu_out(i_alu_out), .i_rs_2(i_rs_2),
    .i_rd_num(i_rd_num), .i_opcode(i_opcode), .i_func_3(i_func_3), .i_op_type(i_op_type),
    .o_stall(o_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd_num(wb_rd_num), .wb_data(wb_data),
    .o_align_err(o_align_err), .o_bus_err(o_bus_err));
  typedef struct {
    logic op; logic [6:0] opc; logic [2:0] f3; logic [31:0] a, d; logic [4:0] rd; int dly;
    logic [31:0] rdata; logic err; logic [3:0] be; logic [31:0] wdata; logic wbwe; logic [31:0] wbdata;
  } vec_t;
  typedef struct {logic [4:0] rd; logic we; logic [31:0] data;} wb_t;
  wb_t exp_q[$];
  int tests = 0, fails = 0;
  vec_t vecs[16];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    wb_t e;
    if (rst_n) begin
      if (wb_valid || o_align_err || o_bus_err)
        chk("exclusive_pulses", 32'(wb_valid) + 32'(o_align_err) + 32'(o_bus_err), 32'd1);
      if (wb_valid) begin
        if (exp_q.size() == 0) chk("wb_unexpected", 32'(wb_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("wb_rd_num", 32'(wb_rd_num), 32'(e.rd));
          chk("wb_we", 32'(wb_we), 32'(e.we));
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  end
  task automatic drive(input vec_t v);
    i_valid = 1; i_op_type = v.op; i_opcode = v.opc; i_func_3 = v.f3;
    i_alu_out = v.a; i_rs_2 = v.d; i_rd_num = v.rd;
  endtask
  task automatic send(input vec_t v);
    int st;
    drive(v);
    if (!v.err) exp_q.push_back('{v.rd, v.wbwe, v.wbdata});
    @(posedge clk); @(negedge clk);
    i_valid = 0;
    if (v.err) begin
      chk("align_err", 32'(o_align_err), 32'd1);
      chk("align_no_req", 32'(mem_req), 32'd0);
    end else if (!v.op) begin
      chk("alu_no_req", 32'(mem_req), 32'd0);
      chk("alu_no_stall", 32'(o_stall), 32'd0);
    end else begin
      chk("mem_addr", mem_addr, {v.a[31:2], 2'b00});
      chk("mem_be", 32'(mem_be), 32'(v.be));
      chk("mem_wdata", mem_wdata, v.wdata);
      chk("mem_we", 32'(mem_we), 32'(v.opc == ST));
      st = 0;
      for (int k = 0; k < v.dly; k++) begin
        if (k > 0) @(negedge clk);
        st += int'(o_stall);
      end
      chk("mem_addr_stable", mem_addr, {v.a[31:2], 2'b00});
      mem_ack = 1; mem_rdata = v.rdata;
      @(negedge clk);
      mem_ack = 0;
      chk("stall_cycles", 32'(st), 32'(v.dly));
      chk("req_drop", 32'(mem_req), 32'd0);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t v;
    int hi;
    logic fell;
    vecs[0]  = '{0, OPI, 3'b000, 32'h15, 0, 5, 0, 0, 0, 0, 0, 1, 32'h15};
    vecs[1]  = '{0, OPI, 3'b000, 32'h15, 0, 5, 0, 0, 0, 0, 0, 1, 32'h15};
    vecs[2]  = '{0, OPI, 3'b000, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99};
    vecs[3]  = '{0, BR, 3'b000, 32'h44, 0, 3, 0, 0, 0, 0, 0, 0, 32'h44};
    vecs[4]  = '{1, LD, 3'b000, 32'h1003, 0, 7, 2, 32'h80FF1234, 0, 4'b1000, 0, 1, 32'hFFFFFF80};
    vecs[5]  = '{1, LD, 3'b100, 32'h1003, 0, 7, 2, 32'h80FF1234, 0, 4'b1000, 0, 1, 32'h00000080};
    vecs[6]  = '{1, ST, 3'b001, 32'h2002, 32'hDEADBEEF, 4, 1, 0, 0, 4'b1100, 32'hBEEFBEEF, 0, 0};
    vecs[7]  = '{1, LD, 3'b010, 32'h3000, 0, 8, 3, 32'h12345678, 0, 4'b1111, 0, 1, 32'h12345678};
    vecs[8]  = '{1, LD, 3'b001, 32'h3002, 0, 9, 1, 32'h80017FFF, 0, 4'b1100, 0, 1, 32'hFFFF8001};
    vecs[9]  = '{1, LD, 3'b101, 32'h3000, 0, 9, 2, 32'h8001F00F, 0, 4'b0011, 0, 1, 32'h0000F00F};
    vecs[10] = '{1, ST, 3'b000, 32'h4001, 32'h123456A5, 1, 1, 0, 0, 4'b0010, 32'hA5A5A5A5, 0, 0};
    vecs[11] = '{1, ST, 3'b010, 32'h4004, 32'hCAFEF00D, 1, 2, 0, 0, 4'b1111, 32'hCAFEF00D, 0, 0};
    vecs[12] = '{1, LD, 3'b010, 32'h1001, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    vecs[13] = '{1, LD, 3'b011, 32'h1000, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    vecs[14] = '{1, ST, 3'b100, 32'h1000, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    vecs[15] = '{1, LD, 3'b000, 32'h5002, 0, 0, 1, 32'h00AA0000, 0, 4'b0100, 0, 0, 32'hFFFFFFAA};
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst_n = 1;
    @(negedge clk);
    foreach (vecs[i]) send(vecs[i]);
    // Timeout: ack never arrives, request must last exactly MAX_WAIT cycles.
    v = '{1, LD, 3'b010, 32'h6000, 0, 1, 0, 0, 0, 4'b1111, 0, 1, 0};
    drive(v);
    @(posedge clk); @(negedge clk);
    i_valid = 0;
    hi = 0; fell = 0;
    for (int k = 0; k < 20 && !fell; k++) begin
      if (mem_req) begin
        hi++;
        @(negedge clk);
      end else begin
        fell = 1;
        chk("bus_err_pulse", 32'(o_bus_err), 32'd1);
      end
    end
    chk("timeout_fell", 32'(fell), 32'd1);
    chk("timeout_req_cycles", 32'(hi), 32'd4);
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 0;
    chk("bus_err_single", 32'(o_bus_err), 32'd0);
    chk("late_ack_no_stall", 32'(o_stall), 32'd0);
    send('{0, OPI, 3'b000, 32'hABC, 0, 6, 0, 0, 0, 0, 0, 1, 32'hABC});
    // Reset while the bus is busy.
    drive('{1, LD, 3'b010, 32'h7000, 0, 3, 0, 0, 0, 4'b1111, 0, 1, 0});
    @(posedge clk); @(negedge clk);
    i_valid = 0;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    rst_n = 0;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_stall", 32'(o_stall), 32'd0);
    chk("async_rst_addr", mem_addr, 32'd0);
    chk("async_rst_be", 32'(mem_be), 32'd0);
    chk("async_rst_wb_data", wb_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_req", 32'(mem_req), 32'd0);
    send('{0, OPI, 3'b000, 32'h77, 0, 2, 0, 0, 0, 0, 0, 1, 32'h77});
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
